// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: adder-sample input and result output handshake bundle
interface sum_accumulator_if #(parameter int WIDTH = 4, parameter int ACC_WIDTH = 12);
  logic start, cout, in_valid, in_ready, ovf, out_valid, out_ready, busy;
  logic [WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] acc;
  modport master(output start, sum, cout, in_valid, out_ready, input in_ready, acc, ovf, out_valid, busy);
  modport slave(input start, sum, cout, in_valid, out_ready, output in_ready, acc, ovf, out_valid, busy);
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT {cout,sum} adder samples into a sticky-overflow accumulator
module sum_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 16,
  parameter int ACC_WIDTH = 12
) (
  input logic clk,
  input logic rst,
  sum_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [ACC_WIDTH-1:0] acc;
  logic ovf, accept, last;
  logic [ACC_WIDTH:0] sum_ext;
  assign accept = state == ACCUM && bus.in_valid;
  assign last = count == CW'(COUNT - 1);
  // one spare bit on top catches the carry out of the accumulator
  assign sum_ext = {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, bus.cout, bus.sum};
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == HOLD;
  assign bus.busy = state != IDLE;
  assign bus.acc = acc;
  assign bus.ovf = ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? ACCUM : IDLE;
      ACCUM: state_nx = accept && last ? HOLD : ACCUM;
      HOLD: state_nx = bus.out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      count <= '0;
    end else if (state == IDLE && bus.start) begin
      acc <= '0;
      ovf <= 1'b0;
      count <= '0;
    end else if (accept) begin
      acc <= sum_ext[ACC_WIDTH-1:0];
      ovf <= ovf | sum_ext[ACC_WIDTH];
      count <= count + 1'b1;
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench running 12-bit and 8-bit accumulators on shared stimulus
module tb_sum_accumulator;
  logic clk = 0, rst = 0;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [11:0] acc; logic ovf; int cyc;} exp_t;
  exp_t q[$], q8[$];
  logic [4:0] smp [16];
  sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(12)) b();
  sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8)) b8();
  assign b8.start = b.start;
  assign b8.sum = b.sum;
  assign b8.cout = b.cout;
  assign b8.in_valid = b.in_valid;
  assign b8.out_ready = b.out_ready;
  sum_accumulator #(.WIDTH(4), .COUNT(16), .ACC_WIDTH(12)) dut (.clk(clk), .rst(rst), .bus(b));
  sum_accumulator #(.WIDTH(4), .COUNT(16), .ACC_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // result appears on out_valid rising; while held it must not move
  logic pv = 0, pv8 = 0, po = 0, po8 = 0;
  logic [11:0] pa = 0;
  logic [7:0] pa8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (b.out_valid && !pv) begin
      if (q.size() == 0) chk("unexpected_result12", 1, 0);
      else begin
        e = q.pop_front();
        chk("acc12", b.acc, e.acc);
        chk("ovf12", b.ovf, e.ovf);
        chk("latency12", cyc, e.cyc);
      end
    end else if (b.out_valid) begin
      chk("hold_acc12", b.acc, pa);
      chk("hold_ovf12", b.ovf, po);
    end
    pv = b.out_valid; pa = b.acc; po = b.ovf;
  end
  always @(negedge clk) begin
    exp_t e;
    if (b8.out_valid && !pv8) begin
      if (q8.size() == 0) chk("unexpected_result8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("acc8", b8.acc, e.acc);
        chk("ovf8", b8.ovf, e.ovf);
        chk("latency8", cyc, e.cyc);
      end
    end else if (b8.out_valid) begin
      chk("hold_acc8", b8.acc, pa8);
      chk("hold_ovf8", b8.ovf, po8);
    end
    pv8 = b8.out_valid; pa8 = b8.acc; po8 = b8.ovf;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // gap: 0 back-to-back, 1 one idle cycle between samples, 2 random idle cycles
  task automatic run_batch(input int gap, input int hold, input bit start_in_hold);
    int total = 0;
    exp_t e, e8;
    b.start = 1;
    tick();
    b.start = 0;
    chk("start_in_ready", b.in_ready, 1);
    chk("start_acc", b.acc, 0);
    chk("start_busy", b.busy, 1);
    chk("start_ovf8", b8.ovf, 0);
    for (int i = 0; i < 16; i++) begin
      repeat (gap == 1 ? (i > 0 ? 1 : 0) : gap == 2 ? int'($urandom_range(0, 2)) : 0) tick();
      b.in_valid = 1;
      {b.cout, b.sum} = smp[i];
      total += smp[i];
      if (i == 15) begin
        e.acc = 12'(total % 4096); e.ovf = total >= 4096; e.cyc = cyc + 1;
        e8.acc = 12'(total % 256); e8.ovf = total >= 256; e8.cyc = cyc + 1;
        q.push_back(e);
        q8.push_back(e8);
      end
      tick();
      b.in_valid = 0;
    end
    for (int h = 0; h < hold; h++) begin
      b.start = start_in_hold;
      b.in_valid = 1'($urandom);
      b.sum = 4'($urandom);
      tick();
      chk("hold_out_valid", b.out_valid, 1);
      chk("hold_in_ready", b.in_ready, 0);
    end
    b.out_ready = 1;
    b.start = start_in_hold;
    tick();
    b.out_ready = 0;
    b.start = 0;
    chk("done_out_valid", b.out_valid, 0);
    chk("done_busy", b.busy, 0);
    chk("done_in_ready", b.in_ready, 0);
    chk("done_acc_kept", b.acc, e.acc);
    b.in_valid = 1;
    b.sum = 4'hF;
    tick();
    tick();
    b.in_valid = 0;
    chk("idle_busy", b.busy, 0);
    chk("idle_acc_kept", b.acc, e.acc);
    chk("idle_acc8_kept", b8.acc, e8.acc[7:0]);
  endtask
  initial begin
    b.start = 0; b.sum = 0; b.cout = 0; b.in_valid = 0; b.out_ready = 0;
    #2 rst = 1;
    #1;
    chk("rst_acc", b.acc, 0);
    chk("rst_ovf", b.ovf, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_in_ready", b.in_ready, 0);
    chk("rst_out_valid", b.out_valid, 0);
    tick(); tick();
    rst = 0;
    tick();
    for (int i = 0; i < 16; i++) smp[i] = 5'h1F;
    run_batch(0, 0, 0);
    for (int i = 0; i < 16; i++) smp[i] = 5'h01;
    run_batch(1, 0, 0);
    for (int i = 0; i < 16; i++) smp[i] = 5'(i);
    run_batch(0, 10, 1);
    b.start = 1;
    tick();
    b.start = 0;
    for (int i = 0; i < 5; i++) begin
      b.in_valid = 1; b.cout = 0; b.sum = 4'h3;
      tick();
    end
    b.in_valid = 0;
    #3 rst = 1;
    #1;
    chk("midrst_acc", b.acc, 0);
    chk("midrst_busy", b.busy, 0);
    chk("midrst_in_ready", b.in_ready, 0);
    #1 rst = 0;
    tick();
    chk("post_rst_idle", b.busy, 0);
    for (int i = 0; i < 16; i++) smp[i] = 5'h02;
    run_batch(0, 0, 0);
    for (int a = 0; a < 16; a++)
      for (int bb = 0; bb < 16; bb++)
        for (int c = 0; c < 2; c++) begin
          int idx = a * 32 + bb * 2 + c;
          smp[idx % 16] = 5'(a + bb + c);
          if (idx % 16 == 15) run_batch(0, 0, 0);
        end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) smp[i] = 5'($urandom);
      run_batch(2, int'($urandom_range(0, 4)), 1'($urandom));
    end
    repeat (3) tick();
    chk("queue12_drained", q.size(), 0);
    chk("queue8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
